// File: rtl/stage_pool_core_if.sv
// Pixel stream bundle for the pooling stage: control, input pixels and pooled results.
interface stage_pool_core_if #(
  parameter int DW = 19,
  parameter int CH = 3
);
  logic            i_clear;
  logic            i_mode;
  logic            i_in_valid;
  logic [CH*DW-1:0] i_in_fmap;
  logic            o_ot_valid;
  logic [CH*DW-1:0] o_ot_fmap;
  logic            o_frame_done;

  modport master (
    output i_clear, i_mode, i_in_valid, i_in_fmap,
    input  o_ot_valid, o_ot_fmap, o_frame_done
  );

  modport slave (
    input  i_clear, i_mode, i_in_valid, i_in_fmap,
    output o_ot_valid, o_ot_fmap, o_frame_done
  );
endinterface

// File: rtl/stage_pool_core.sv
// Non-overlapping POOLxPOOL max/average pooling over a raster stream of CH-channel pixels,
// keeping only one partial accumulator per window column instead of a raw line buffer.
module stage_pool_core #(
  parameter int DW     = 19,
  parameter int COL    = 24,
  parameter int ROW    = 24,
  parameter int CH     = 3,
  parameter int POOL   = 2,
  parameter int SIGNED = 1
) (
  input logic              clk,
  input logic              reset_n,
  stage_pool_core_if.slave pif
);

  localparam int LP = $clog2(POOL);
  localparam int AW = DW + 2 * LP;
  localparam int NW = COL / POOL;
  localparam int CW = $clog2(COL);
  localparam int RW = $clog2(ROW);
  localparam int WW = (NW > 1) ? $clog2(NW) : 1;

  typedef logic [AW-1:0] acc_t;

  // Widening by 2*LP leaves headroom for the POOL*POOL sum in average mode.
  function automatic acc_t ext(input logic [DW-1:0] s);
    if (SIGNED != 0) return {{(AW-DW){s[DW-1]}}, s};
    return {{(AW-DW){1'b0}}, s};
  endfunction

  function automatic acc_t merge(input logic avg, input acc_t a, input acc_t b);
    logic a_gt;
    if (avg) return a + b;
    a_gt = (SIGNED != 0) ? ($signed(a) > $signed(b)) : (a > b);
    return a_gt ? a : b;
  endfunction

  logic [CW-1:0]    col_q;
  logic [RW-1:0]    row_q;
  logic             mode_q;
  acc_t             hrun_q [CH];
  acc_t             pbuf_q [NW][CH];
  logic             ot_valid_q;
  logic             frame_done_q;
  logic [CH*DW-1:0] ot_fmap_q;

  logic             first_px;
  logic             mode_eff;
  logic [LP-1:0]    col_ph;
  logic [LP-1:0]    row_ph;
  logic [WW-1:0]    win_idx;
  logic             win_end;
  logic             win_done;
  logic             last_px;
  acc_t             h_new [CH];
  acc_t             v_new [CH];
  logic [CH*DW-1:0] res;

  // The first pixel of a frame must already use the mode it is latching.
  assign first_px = (col_q == '0) && (row_q == '0);
  assign mode_eff = first_px ? pif.i_mode : mode_q;
  assign col_ph   = col_q[LP-1:0];
  assign row_ph   = row_q[LP-1:0];
  assign win_idx  = WW'(col_q >> LP);
  assign win_end  = (col_ph == LP'(POOL - 1));
  assign win_done = win_end && (row_ph == LP'(POOL - 1));
  assign last_px  = (col_q == CW'(COL - 1)) && (row_q == RW'(ROW - 1));

  always_comb begin
    res = '0;
    for (int c = 0; c < CH; c++) begin
      h_new[c] = (col_ph == '0) ? ext(pif.i_in_fmap[c*DW +: DW])
                                : merge(mode_eff, hrun_q[c], ext(pif.i_in_fmap[c*DW +: DW]));
      v_new[c] = (row_ph == '0) ? h_new[c] : merge(mode_eff, pbuf_q[win_idx][c], h_new[c]);
      // Taking the top DW bits of the sum is an arithmetic shift, i.e. floor division.
      res[c*DW +: DW] = mode_eff ? v_new[c][AW-1 -: DW] : v_new[c][DW-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q        <= '0;
      row_q        <= '0;
      mode_q       <= 1'b0;
      ot_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      ot_fmap_q    <= '0;
      for (int c = 0; c < CH; c++) begin
        hrun_q[c] <= '0;
        for (int w = 0; w < NW; w++) pbuf_q[w][c] <= '0;
      end
    end else begin
      ot_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      if (pif.i_clear) begin
        col_q  <= '0;
        row_q  <= '0;
        mode_q <= 1'b0;
        for (int c = 0; c < CH; c++) begin
          hrun_q[c] <= '0;
          for (int w = 0; w < NW; w++) pbuf_q[w][c] <= '0;
        end
      end else if (pif.i_in_valid) begin
        if (first_px) mode_q <= pif.i_mode;
        for (int c = 0; c < CH; c++) begin
          hrun_q[c] <= h_new[c];
          if (win_end) pbuf_q[win_idx][c] <= v_new[c];
        end
        if (win_done) begin
          ot_valid_q   <= 1'b1;
          ot_fmap_q    <= res;
          frame_done_q <= last_px;
        end
        if (col_q == CW'(COL - 1)) begin
          col_q <= '0;
          row_q <= (row_q == RW'(ROW - 1)) ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

  assign pif.o_ot_valid   = ot_valid_q;
  assign pif.o_ot_fmap    = ot_fmap_q;
  assign pif.o_frame_done = frame_done_q;

endmodule
